sub_arbiter: RTL



---
 rtl/vec_pkg.sv | 20 ++
 rtl/sub_arbiter_if.sv | 33 +++
 rtl/sub_arbiter_tag_fifo.sv | 68 ++++++
 rtl/sub_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared vector types for the fifo_math subtract path and its arbiter.
// A vector is ARRAY_SIZE signed lanes; requesters are identified by a one-bit id.
package vec_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ARRAY_SIZE = 3;
    localparam int NUM_REQ    = 2;

    typedef logic signed [DATA_WIDTH-1:0] lane_t;
    typedef lane_t [ARRAY_SIZE-1:0]       vec_t;
    typedef logic                         req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    function automatic req_id_t other_req(input req_id_t r);
        return req_id_t'(~r);
    endfunction

endpackage

// File: rtl/sub_arbiter_if.sv
// Operand, subtract-unit and result signals shared between sub_arbiter and its environment.
// master is the arbiter side; slave is the requesters plus the shared sub unit.
interface sub_arbiter_if;
    import vec_pkg::*;

    vec_t [NUM_REQ-1:0] req_x;
    vec_t [NUM_REQ-1:0] req_y;
    logic [NUM_REQ-1:0] req_empty;
    logic [NUM_REQ-1:0] req_rd_en;

    vec_t               sub_x;
    vec_t               sub_y;
    logic               sub_in_empty;
    logic               sub_in_rd_en;
    vec_t               sub_out;
    logic               sub_out_empty;
    logic               sub_out_rd_en;

    vec_t [NUM_REQ-1:0] res_out;
    logic [NUM_REQ-1:0] res_empty;
    logic [NUM_REQ-1:0] res_rd_en;

    modport master (
        input  req_x, req_y, req_empty, sub_in_rd_en, sub_out, sub_out_empty, res_rd_en,
        output req_rd_en, sub_x, sub_y, sub_in_empty, sub_out_rd_en, res_out, res_empty
    );

    modport slave (
        output req_x, req_y, req_empty, sub_in_rd_en, sub_out, sub_out_empty, res_rd_en,
        input  req_rd_en, sub_x, sub_y, sub_in_empty, sub_out_rd_en, res_out, res_empty
    );

endinterface

// File: rtl/sub_arbiter_tag_fifo.sv
// First-word-fall-through FIFO of requester ids, one entry per operation inside sub.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module tag_fifo
    import vec_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    input  logic          push_i,
    input  req_id_t       data_i,
    input  logic          pop_i,
    output req_id_t       data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    req_id_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin sharing of one vector subtract unit between two FWFT requesters.
// Issued operations are tagged with their requester so results return in issue order.
module sub_arbiter
    import vec_pkg::*;
#(
    parameter int TAG_DEPTH = 16,
    parameter int MAX_BURST = 4
) (
    input logic           clock_i,
    input logic           reset_ni,
    sub_arbiter_if.master bus
);

    localparam int CW = $clog2(TAG_DEPTH) + 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    req_id_t            last_q, last_d;
    logic [BW-1:0]      burst_q, burst_d;
    req_id_t            grant;
    logic               any_req;
    logic               in_burst;
    logic               in_empty;
    logic               issue;

    req_id_t            tag_head;
    logic [CW-1:0]      tag_count;
    logic               tag_full;
    logic               tag_empty;
    logic               tag_pop;
    logic [NUM_REQ-1:0] res_empty;

    assign any_req  = ~&bus.req_empty;
    // burst_q == 0 only right after reset, so the first tie goes to other_req(last_q).
    assign in_burst = (burst_q != '0) && (burst_q < BW'(MAX_BURST));

    always_comb begin
        grant = last_q;
        if (!bus.req_empty[0] && bus.req_empty[1]) begin
            grant = REQ0;
        end else if (bus.req_empty[0] && !bus.req_empty[1]) begin
            grant = REQ1;
        end else if (!bus.req_empty[0] && !bus.req_empty[1]) begin
            grant = in_burst ? last_q : other_req(last_q);
        end
    end

    always_comb begin
        in_empty      = ~reset_ni | ~any_req | tag_full;
        issue         = bus.sub_in_rd_en & ~in_empty;
        bus.req_rd_en = '0;
        if (issue) begin
            bus.req_rd_en[grant] = 1'b1;
        end
        bus.sub_in_empty = in_empty;
        bus.sub_x        = bus.req_x[grant];
        bus.sub_y        = bus.req_y[grant];
    end

    always_comb begin
        last_d  = last_q;
        burst_d = burst_q;
        if (issue) begin
            if (grant == last_q) begin
                if (burst_q < BW'(MAX_BURST)) begin
                    burst_d = burst_q + BW'(1);
                end
            end else begin
                last_d  = grant;
                burst_d = BW'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            last_q  <= REQ1;
            burst_q <= '0;
        end else begin
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .push_i   (issue),
        .data_i   (grant),
        .pop_i    (tag_pop),
        .data_o   (tag_head),
        .count_o  (tag_count),
        .full_o   (tag_full),
        .empty_o  (tag_empty)
    );

    // Only the requester owning the head tag may see the result; the other is blocked.
    always_comb begin
        res_empty = '1;
        for (int r = 0; r < NUM_REQ; r++) begin
            res_empty[r]   = ~reset_ni | bus.sub_out_empty | tag_empty | (tag_head != req_id_t'(r));
            bus.res_out[r] = bus.sub_out;
        end
        tag_pop           = bus.res_rd_en[tag_head] & ~res_empty[tag_head];
        bus.sub_out_rd_en = tag_pop;
        bus.res_empty     = res_empty;
    end

    a_full_matches_count : assert property (
        @(posedge clock_i) disable iff (!reset_ni) tag_full == (tag_count == CW'(TAG_DEPTH))
    );

    a_single_pop : assert property (
        @(posedge clock_i) disable iff (!reset_ni) $onehot0(bus.req_rd_en)
    );

endmodule
